// File: rtl/axi_lite_timer.sv
// AXI4-Lite timer/counter: 32-bit prescaled down-counter with one-shot or auto-reload
// modes and a level interrupt. Only the in-window offset addr[11:2] is decoded.
module axi_lite_timer #(
    parameter int AXI_ADDR_BW_p = 15,
    parameter int AXI_DATA_BW_p = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [AXI_ADDR_BW_p-1:0] s_awaddr_i,
    input  logic                     s_awvalid_i,
    output logic                     s_awready_o,
    input  logic [31:0]              s_wdata_i,
    input  logic [3:0]               s_wstrb_i,
    input  logic                     s_wvalid_i,
    output logic                     s_wready_o,
    output logic [1:0]               s_bresp_o,
    output logic                     s_bvalid_o,
    input  logic                     s_bready_i,
    input  logic [AXI_ADDR_BW_p-1:0] s_araddr_i,
    input  logic                     s_arvalid_i,
    output logic                     s_arready_o,
    output logic [31:0]              s_rdata_o,
    output logic [1:0]               s_rresp_o,
    output logic                     s_rvalid_o,
    input  logic                     s_rready_i,
    output logic                     irq_o
);

    generate
        if (AXI_DATA_BW_p != 32) begin : g_bad_data_bw
            $error("axi_lite_timer: AXI_DATA_BW_p must be 32");
        end
    endgenerate

    localparam logic [9:0] OFF_CTRL   = 10'd0;
    localparam logic [9:0] OFF_LOAD   = 10'd1;
    localparam logic [9:0] OFF_COUNT  = 10'd2;
    localparam logic [9:0] OFF_STATUS = 10'd3;
    localparam logic [9:0] OFF_PRESC  = 10'd4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  stb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = stb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

    // registers
    logic [2:0]  r_ctrl;          // {IRQ_EN, AUTO_RELOAD, EN}
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_pend;
    logic [31:0] r_prescale;
    logic [31:0] r_pcnt;

    // write channel holding registers
    logic        r_aw_held;
    logic [9:0]  r_awoff;
    logic        r_w_held;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    // read channel
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr;
    logic [9:0]  w_woff, w_roff;
    logic [31:0] w_wdat;
    logic [3:0]  w_wstb;
    logic        w_wr_ctrl, w_wr_load, w_wr_status, w_wr_presc, w_woff_ok;
    logic [31:0] w_load_new, w_presc_new;
    logic        w_tick, w_expire, w_w1c;
    logic [31:0] w_rd;
    logic        w_rerr;
    logic        w_unused;

    assign w_unused = ^{s_awaddr_i[AXI_ADDR_BW_p-1:12], s_awaddr_i[1:0],
                        s_araddr_i[AXI_ADDR_BW_p-1:12], s_araddr_i[1:0]};

    assign s_awready_o = !r_aw_held && !r_bvalid;
    assign s_wready_o  = !r_w_held && !r_bvalid;
    assign s_bvalid_o  = r_bvalid;
    assign s_bresp_o   = r_bresp;
    assign s_arready_o = !r_rvalid;
    assign s_rvalid_o  = r_rvalid;
    assign s_rdata_o   = r_rdata;
    assign s_rresp_o   = r_rresp;
    assign irq_o       = r_pend & r_ctrl[2];

    assign w_aw_hs = s_awvalid_i && s_awready_o;
    assign w_w_hs  = s_wvalid_i && s_wready_o;
    assign w_ar_hs = s_arvalid_i && s_arready_o;

    // A held beat and a fresh beat on the other channel complete the write together.
    assign w_woff = r_aw_held ? r_awoff : s_awaddr_i[11:2];
    assign w_wdat = r_w_held ? r_wdata : s_wdata_i;
    assign w_wstb = r_w_held ? r_wstrb : s_wstrb_i;
    assign w_wr   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_woff_ok   = (w_woff <= OFF_PRESC);
    assign w_wr_ctrl   = w_wr && (w_woff == OFF_CTRL);
    assign w_wr_load   = w_wr && (w_woff == OFF_LOAD);
    assign w_wr_status = w_wr && (w_woff == OFF_STATUS);
    assign w_wr_presc  = w_wr && (w_woff == OFF_PRESC);
    assign w_load_new  = f_merge(r_load, w_wdat, w_wstb);
    assign w_presc_new = f_merge(r_prescale, w_wdat, w_wstb);

    assign w_tick   = r_ctrl[0] && (r_pcnt == r_prescale);
    assign w_expire = w_tick && (r_count == 32'd0);
    assign w_w1c    = w_wr_status && w_wstb[0] && w_wdat[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_held <= 1'b0;
            r_awoff   <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_wr) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_woff_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awoff   <= s_awaddr_i[11:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_wdata_i;
                    r_wstrb  <= s_wstrb_i;
                end
                if (r_bvalid && s_bready_i)
                    r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl     <= '0;
            r_load     <= '0;
            r_count    <= '0;
            r_pend     <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            // software CTRL write overrides the one-shot EN clear
            if (w_wr_ctrl && w_wstb[0])
                r_ctrl <= w_wdat[2:0];
            else if (w_expire && !r_ctrl[1])
                r_ctrl[0] <= 1'b0;

            if (w_wr_load)
                r_load <= w_load_new;
            if (w_wr_presc)
                r_prescale <= w_presc_new;

            if (w_wr_load)
                r_count <= w_load_new;
            else if (w_tick) begin
                if (r_count != 32'd0)
                    r_count <= r_count - 32'd1;
                else if (r_ctrl[1])
                    r_count <= r_load;
            end

            if (w_wr_load || !r_ctrl[0] || w_tick)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + 32'd1;

            r_pend <= w_expire || (r_pend && !w_w1c);
        end
    end

    assign w_roff = s_araddr_i[11:2];

    always_comb begin
        w_rd   = '0;
        w_rerr = 1'b0;
        case (w_roff)
            OFF_CTRL:   w_rd = {29'd0, r_ctrl};
            OFF_LOAD:   w_rd = r_load;
            OFF_COUNT:  w_rd = r_count;
            OFF_STATUS: w_rd = {31'd0, r_pend};
            OFF_PRESC:  w_rd = r_prescale;
            default:    w_rerr = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd;
            r_rresp  <= w_rerr ? RESP_SLVERR : RESP_OKAY;
        end else if (r_rvalid && s_rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: doc/axi_lite_timer.md
Name: axi_lite_timer

Overview:
- AXI4-Lite responder for the Timer/Counter slot of the crossbar: slave index 0, window 0x1000–0x1FFF, 4 KiB.
- 32-bit down-counter with programmable prescaler, one-shot or auto-reload mode, and a level interrupt for the picorv32 IRQ input.
- The crossbar performs address decode; this block uses only the in-window offset.

Parameters:
- AXI_ADDR_BW_p, 15, AXI address width. Only bits [11:2] are decoded.
- AXI_DATA_BW_p, 32, AXI data width. Fixed at 32; elaboration error otherwise.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_awaddr_i  in  AXI_ADDR_BW_p  write address
- s_awvalid_i / s_awready_o  in/out  1  AW handshake
- s_wdata_i  in  32  write data
- s_wstrb_i  in  4  byte enables
- s_wvalid_i / s_wready_o  in/out  1  W handshake
- s_bresp_o  out  2  write response
- s_bvalid_o / s_bready_i  out/in  1  B handshake
- s_araddr_i  in  AXI_ADDR_BW_p  read address
- s_arvalid_i / s_arready_o  in/out  1  AR handshake
- s_rdata_o  out  32  read data
- s_rresp_o  out  2  read response
- s_rvalid_o / s_rready_i  out/in  1  R handshake
- irq_o  out  1  timer interrupt, level

Behaviour:
- Register map (offset = addr[11:2]*4; addr[1:0] and bits above 11 ignored):
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 LOAD, RW.
  - 0x08 COUNT, RO.
  - 0x0C STATUS: bit0 PEND, write-1-to-clear.
  - 0x10 PRESCALE, RW.
  - Other offsets: reads return 0 with RRESP=SLVERR (2'b10); writes have no effect and return BRESP=SLVERR.
- Reset values: all registers 0. Prescaler counter 0. bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, irq_o=0. awready=wready=arready=1.
- Write path:
  - AW and W are captured independently into one-entry holding registers.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W may arrive in either order, or in the same cycle.
  - When both are held, or arrive together, the register update happens in that cycle. bvalid asserts the next cycle and both holding registers clear.
  - bvalid holds until bready. No new AW/W is accepted while bvalid=1. At most one write is outstanding.
  - WSTRB is honoured per byte on CTRL, LOAD and PRESCALE.
  - STATUS W1C uses byte 0 only.
  - A LOAD write also copies the merged value into COUNT and clears the prescaler counter.
- Read path:
  - arready = !rvalid.
  - On AR handshake, rdata/rresp are registered and rvalid asserts the next cycle, i.e. 1-cycle latency.
  - rdata is held stable until rready.
  - COUNT returns its value in the AR-accept cycle. A same-cycle write is not visible to that read.
- Counter:
  - With EN=1, the prescaler counter increments each cycle. A tick fires when it equals PRESCALE, and it wraps to 0 on that tick. PRESCALE=0 gives a tick every cycle.
  - On a tick with COUNT!=0: COUNT decrements.
  - On a tick with COUNT==0: PEND is set. If AUTO_RELOAD=1, COUNT<=LOAD. If AUTO_RELOAD=0, EN clears (one-shot) and COUNT stays 0.
  - EN=0: COUNT is frozen and the prescaler counter is held at 0.
  - No wrap below 0.
- Interrupt:
  - irq_o = PEND & IRQ_EN, a combinational AND of two flops.
  - A hardware PEND set and a software W1C in the same cycle resolve to set.
- Simultaneous events:
  - Hardware one-shot EN clear and a software CTRL write in the same cycle resolve to the software value.
  - A LOAD write on a tick cycle: the load wins over the decrement.
- Reset mid-transaction: async reset drops bvalid/rvalid immediately, discards held AW/W, and returns all registers to reset values.

Test Plan:
- Reset: deassert rst_ni → awready=wready=arready=1, bvalid=rvalid=irq_o=0. Read 0x08 → 0, OKAY.
- One-shot: write LOAD=5, PRESCALE=0, CTRL=0x5 → COUNT reads 5,4,…,0. PEND=1 and irq_o=1 on the 6th tick. CTRL reads 0x4. COUNT stays 0.
- Auto-reload with prescale: LOAD=2, PRESCALE=3, CTRL=0x7 → PEND every 12 cycles. Write STATUS=1 → irq_o drops the cycle after the write. Force W1C on a tick cycle → PEND stays 1.
- Channel ordering and backpressure: present AW for 0x04 three cycles before W=0xDEADBEEF → bvalid only after W. Hold bready=0 for 4 cycles → bvalid stays 1, awready=wready=0. LOAD reads 0xDEADBEEF.
- Strobes: write PRESCALE=0xAABBCCDD with wstrb=4'b0101 over 0 → readback 0x00BB00DD.
- Error decode: read 0x014 → rdata=0, rresp=2'b10. Write 0x018 → bresp=2'b10, no register changes. Hold rready=0 → rvalid and rdata held, arready=0.
